fsm_input_conditioner: RTL and testbench
========================================

# fsm_input_conditioner

Input-conditioning stage directly upstream of the one-hot control FSM that consumes A0, A4 and I3. Takes three raw, asynchronous level inputs, synchronises each into the clk domain, and debounces it. It then drives clean, glitch-free levels on A0/A4/I3 to the FSM, plus a one-cycle change strobe with a per-channel mask for monitoring. All three channels are identical and fully independent.

## Interface
- SYNC_STAGES, 2, synchroniser flops per channel (legal ≥ 2)
- DB_CYCLES, 4, consecutive clk cycles a synchronised value must differ from the output before the output takes it (legal 1..2^CNT_W)
- CNT_W, 3, width of each debounce counter
- RST_VAL, 3'b000, reset value of {I3, A4, A0} and of every synchroniser flop
- clk  in  1  system clock, all state on rising edge
- rst_b  in  1  reset, asynchronous, active-low
- a0_raw  in  1  raw asynchronous level, channel 0
- a4_raw  in  1  raw asynchronous level, channel 1
- i3_raw  in  1  raw asynchronous level, channel 2
- A0  out  1  conditioned level, channel 0 (registered)
- A4  out  1  conditioned level, channel 1 (registered)
- I3  out  1  conditioned level, channel 2 (registered)
- chg  out  1  one-cycle pulse: at least one conditioned output changed on the previous edge
- chg_mask  out  3  {I3, A4, A0} channels that changed on the previous edge; all-zero whenever chg=0

## Operation
- Per channel: SYNC_STAGES-deep flop chain. Its last stage is s. Plus a debounce counter cnt[CNT_W-1:0] and an output register out.
- Per-channel state machine with two states, derived from cnt and the compare s vs out. No separate state register is required.
  - STABLE: s == out, cnt == 0.
  - PENDING: s != out, cnt counts consecutive differing cycles.
- Update rule on each rising clk edge:
  - If s == out: cnt <= 0 and out holds. A PENDING channel returns to STABLE, so a glitch is discarded.
  - If s != out and cnt == DB_CYCLES-1: out <= s and cnt <= 0.
  - If s != out and cnt < DB_CYCLES-1: cnt <= cnt+1.
- cnt never exceeds DB_CYCLES-1 and never wraps.
- DB_CYCLES=1: out takes s on the first differing edge.
- chg_mask[i] <= (channel i updated out on this edge). chg <= |(that same vector). Both are registered, so they are high for exactly one cycle after the update.
- Simultaneous changes on several channels in the same cycle: each channel is independent. chg_mask shows every channel that updated on that edge, and chg pulses once.
- Back-to-back updates on consecutive edges on different channels: chg stays high for both cycles, and chg_mask holds the correct set each cycle.
- Reset (asserted at any time, including mid-PENDING):
  - All synchroniser flops and outputs go to RST_VAL.
  - Every cnt goes to 0.
  - chg and chg_mask go to 0.
  - Any in-progress count is discarded.
- After rst_b deasserts, raw inputs that differ from RST_VAL propagate with the full latency below.

## Timing
- Reset values: A0/A4/I3 = RST_VAL bits; chg = 0; chg_mask = 3'b000.
- Let raw change settle before edge k, then stay stable. Then:
  - Synchroniser stages capture it on edges k .. k+SYNC_STAGES-1.
  - Counting starts at edge k+SYNC_STAGES.
  - Output updates at edge k+SYNC_STAGES+DB_CYCLES-1.
  - chg pulses in the cycle after that edge.
- Defaults: output at edge k+5, chg high between edges k+5 and k+6.
- Rejection: a raw pulse held for fewer than DB_CYCLES cycles (as seen at s) never reaches the output.
- Acceptance: a pulse held for DB_CYCLES or more cycles always reaches the output.
- Outputs are purely registered, with no combinational path from raw inputs. They are safe to feed the FSM next-state logic directly.

## Test plan
- Reset: rst_b=0 with raws at 1 → A0=A4=I3=0, chg=0, chg_mask=0. Release at edge 0 with raws held at 1 → all three outputs go to 1 at edge 5, chg=1 and chg_mask=3'b111 for one cycle, then chg=0.
- Glitch rejection: a0_raw high for 3 clk cycles then low → A0 stays 0, chg never asserts.
- Threshold: a4_raw high for exactly 4 cycles → A4 rises 5 edges after the first capture edge and falls 5 edges after the falling capture edge. chg_mask=3'b010 on both pulses.
- Bounce inside PENDING: i3_raw 1,1,0,1,1,1,1 (one value per cycle) → counter restarts after the 0. I3 rises 5 edges after the last restart, not earlier.
- Independent channels: a0_raw rises at edge 0 and i3_raw rises at edge 1 → A0 at edge 5 with chg_mask=3'b001, I3 at edge 6 with chg_mask=3'b100. chg is high for two consecutive cycles.
- Reset mid-operation: a0_raw rises, then rst_b asserts 3 edges later for 1 cycle → A0=0, cnt cleared. After release, A0 rises 5 edges after the first post-reset capture edge.

Source files
------------

// File: rtl/fsm_input_conditioner_if.sv
// Raw level inputs and conditioned outputs between the input pins and the
// downstream one-hot control FSM.
interface fsm_input_conditioner_if;
  logic       a0_raw;
  logic       a4_raw;
  logic       i3_raw;
  logic       A0;
  logic       A4;
  logic       I3;
  logic       chg;
  logic [2:0] chg_mask;

  // master supplies the raw levels, slave is the conditioner itself
  modport master (
    output a0_raw, a4_raw, i3_raw,
    input  A0, A4, I3, chg, chg_mask
  );

  modport slave (
    input  a0_raw, a4_raw, i3_raw,
    output A0, A4, I3, chg, chg_mask
  );
endinterface

// File: rtl/fsm_input_conditioner.sv
// Synchronises and debounces three independent raw levels (A0, A4, I3) and
// reports which channels changed with a registered one-cycle strobe.
module fsm_input_conditioner #(
  parameter int         SYNC_STAGES = 2,
  parameter int         DB_CYCLES   = 4,
  parameter int         CNT_W       = 3,
  parameter logic [2:0] RST_VAL     = 3'b000
) (
  input  logic                    clk,
  input  logic                    rst_b,
  fsm_input_conditioner_if.slave  io_cond
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [2:0] w_raw;
  logic [2:0] w_out;
  logic [2:0] w_upd;
  logic       r_chg;
  logic [2:0] r_chg_mask;

  assign w_raw = {io_cond.i3_raw, io_cond.a4_raw, io_cond.a0_raw};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      logic [CNT_W-1:0]       w_cnt_next;
      logic                   r_out;
      logic                   w_out_next;
      logic                   w_s;
      logic                   w_upd_ch;
      state_t                 w_state;

      assign w_s = r_sync[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          r_sync <= {SYNC_STAGES{RST_VAL[gi]}};
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
        end
      end

      // State is implied by the s/out compare; cnt only matters while PENDING
      always_comb begin
        w_state    = (w_s != r_out) ? ST_PENDING : ST_STABLE;
        w_cnt_next = '0;
        w_out_next = r_out;
        w_upd_ch   = 1'b0;
        case (w_state)
          ST_STABLE: begin
            w_cnt_next = '0;
          end
          ST_PENDING: begin
            if (r_cnt == CNT_LAST) begin
              w_out_next = w_s;
              w_upd_ch   = 1'b1;
            end else begin
              w_cnt_next = r_cnt + CNT_W'(1);
            end
          end
          default: begin
            w_cnt_next = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          r_cnt <= '0;
          r_out <= RST_VAL[gi];
        end else begin
          r_cnt <= w_cnt_next;
          r_out <= w_out_next;
        end
      end

      assign w_out[gi] = r_out;
      assign w_upd[gi] = w_upd_ch;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_chg      <= 1'b0;
      r_chg_mask <= 3'b000;
    end else begin
      r_chg      <= |w_upd;
      r_chg_mask <= w_upd;
    end
  end

  assign io_cond.A0       = w_out[0];
  assign io_cond.A4       = w_out[1];
  assign io_cond.I3       = w_out[2];
  assign io_cond.chg      = r_chg;
  assign io_cond.chg_mask = r_chg_mask;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Self-checking bench: directed scenarios plus random levels, compared against a
// window-based model (output flips when the last DB synchronised samples all differ).
module tb_fsm_input_conditioner;
  localparam int         SYNC = 2;
  localparam int         DB   = 4;
  localparam int         CW   = 3;
  localparam logic [2:0] RV   = 3'b000;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  fsm_input_conditioner_if cif ();

  fsm_input_conditioner #(
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB),
    .CNT_W       (CW),
    .RST_VAL     (RV)
  ) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .io_cond (cif)
  );

  always #5 clk = ~clk;

  logic [6:0] w_obs;
  assign w_obs = {cif.I3, cif.A4, cif.A0, cif.chg, cif.chg_mask};

  // Reference model state
  logic [2:0] raw_q[$];
  logic [2:0] sv_q[$];
  logic [2:0] m_out;
  logic [2:0] m_mask;
  logic       m_chg;
  logic [6:0] m_exp;

  task automatic model_reset();
    raw_q.delete();
    sv_q.delete();
    for (int i = 0; i < SYNC; i++) raw_q.push_back(RV);
    for (int i = 0; i < DB; i++) sv_q.push_back(RV);
    m_out  = RV;
    m_mask = 3'b000;
    m_chg  = 1'b0;
    m_exp  = {m_out, m_chg, m_mask};
  endtask

  task automatic model_step(input logic [2:0] raw);
    logic [2:0] sval;
    logic [2:0] upd;
    sval = raw_q.pop_front();
    raw_q.push_back(raw);
    sv_q.push_back(sval);
    void'(sv_q.pop_front());
    upd = 3'b111;
    foreach (sv_q[j]) upd = upd & (sv_q[j] ^ m_out);
    m_out  = m_out ^ upd;
    m_mask = upd;
    m_chg  = |upd;
    m_exp  = {m_out, m_chg, m_mask};
  endtask

  // Drive one cycle's inputs at the falling edge, then land 1 time unit after the rising edge
  task automatic cycle(input logic [2:0] raw, input logic rb);
    @(negedge clk);
    cif.a0_raw = raw[0];
    cif.a4_raw = raw[1];
    cif.i3_raw = raw[2];
    rst_b      = rb;
    if (!rb) model_reset();
    @(posedge clk);
    if (rst_b) model_step(raw);
    else model_reset();
    #1;
  endtask

  task automatic apply_reset();
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    repeat (3) cycle(3'b000, 1'b1);
  endtask

  task automatic test_reset();
    logic [6:0] req;
    repeat (3) begin
      cycle(3'b111, 1'b0);
      checks++;
      if (w_obs !== 7'b000_0_000) begin
        failures++;
        $display("FAIL reset_hold got=%b exp=%b", w_obs, 7'b000_0_000);
      end
    end
    for (int e = 0; e < 8; e++) begin
      cycle(3'b111, 1'b1);
      req = (e < 5) ? 7'b000_0_000 : (e == 5) ? 7'b111_1_111 : 7'b111_0_000;
      checks++;
      if (w_obs !== req) begin
        failures++;
        $display("FAIL reset_release e=%0d got=%b exp=%b", e, w_obs, req);
      end
      checks++;
      if (w_obs !== m_exp) begin
        failures++;
        $display("FAIL model_reset e=%0d got=%b exp=%b", e, w_obs, m_exp);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int e = 0; e < 14; e++) begin
      cycle((e < 3) ? 3'b001 : 3'b000, 1'b1);
      checks++;
      if (cif.A0 !== 1'b0 || cif.chg !== 1'b0) begin
        failures++;
        $display("FAIL glitch e=%0d got A0=%b chg=%b exp A0=0 chg=0", e, cif.A0, cif.chg);
      end
      checks++;
      if (w_obs !== m_exp) begin
        failures++;
        $display("FAIL model_glitch e=%0d got=%b exp=%b", e, w_obs, m_exp);
      end
    end
  endtask

  task automatic test_threshold();
    int rise = -1;
    int fall = -1;
    apply_reset();
    for (int e = 0; e < 16; e++) begin
      cycle((e < 4) ? 3'b010 : 3'b000, 1'b1);
      if (cif.A4 === 1'b1 && rise < 0) rise = e;
      if (cif.A4 === 1'b0 && rise >= 0 && fall < 0) fall = e;
      if (cif.chg === 1'b1) begin
        checks++;
        if (cif.chg_mask !== 3'b010) begin
          failures++;
          $display("FAIL threshold_mask e=%0d got=%b exp=010", e, cif.chg_mask);
        end
      end
      checks++;
      if (w_obs !== m_exp) begin
        failures++;
        $display("FAIL model_threshold e=%0d got=%b exp=%b", e, w_obs, m_exp);
      end
    end
    checks++;
    if (rise != 5 || fall != 9) begin
      failures++;
      $display("FAIL threshold_timing got rise=%0d fall=%0d exp rise=5 fall=9", rise, fall);
    end
  endtask

  task automatic test_bounce();
    logic [6:0] seq;
    int rise = -1;
    seq = 7'b1111011;  // bit e is i3_raw for edge e: 1,1,0,1,1,1,1
    apply_reset();
    for (int e = 0; e < 14; e++) begin
      cycle({(e < 7) ? seq[e] : 1'b1, 2'b00}, 1'b1);
      if (cif.I3 === 1'b1 && rise < 0) rise = e;
      checks++;
      if (w_obs !== m_exp) begin
        failures++;
        $display("FAIL model_bounce e=%0d got=%b exp=%b", e, w_obs, m_exp);
      end
    end
    checks++;
    if (rise != 8) begin
      failures++;
      $display("FAIL bounce_rise got=%0d exp=8", rise);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] req;
    apply_reset();
    for (int e = 0; e < 10; e++) begin
      cycle({(e >= 1) ? 1'b1 : 1'b0, 2'b01}, 1'b1);
      req = (e < 5)  ? 7'b000_0_000 :
            (e == 5) ? 7'b001_1_001 :
            (e == 6) ? 7'b101_1_100 : 7'b101_0_000;
      checks++;
      if (w_obs !== req) begin
        failures++;
        $display("FAIL back_to_back e=%0d got=%b exp=%b", e, w_obs, req);
      end
      checks++;
      if (w_obs !== m_exp) begin
        failures++;
        $display("FAIL model_b2b e=%0d got=%b exp=%b", e, w_obs, m_exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rise = -1;
    apply_reset();
    repeat (3) cycle(3'b001, 1'b1);
    cycle(3'b001, 1'b0);
    checks++;
    if (w_obs !== 7'b000_0_000) begin
      failures++;
      $display("FAIL reset_mid_clear got=%b exp=%b", w_obs, 7'b000_0_000);
    end
    for (int e = 0; e < 9; e++) begin
      cycle(3'b001, 1'b1);
      if (cif.A0 === 1'b1 && rise < 0) rise = e;
      checks++;
      if (w_obs !== m_exp) begin
        failures++;
        $display("FAIL model_reset_mid e=%0d got=%b exp=%b", e, w_obs, m_exp);
      end
    end
    checks++;
    if (rise != 5) begin
      failures++;
      $display("FAIL reset_mid_rise got=%0d exp=5", rise);
    end
  endtask

  task automatic test_random();
    logic [2:0] cur = 3'b000;
    int         hold[3] = '{1, 1, 1};
    int         shown = 0;
    logic       rb;
    apply_reset();
    for (int e = 0; e < 3000; e++) begin
      for (int c = 0; c < 3; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          cur[c]  = ~cur[c];
          hold[c] = int'($urandom_range(1, 7));
        end
      end
      rb = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      cycle(cur, rb);
      checks++;
      if (w_obs !== m_exp) begin
        failures++;
        if (shown < 20) begin
          shown++;
          $display("FAIL model_random e=%0d got=%b exp=%b", e, w_obs, m_exp);
        end
      end
    end
  endtask

  initial begin
    cif.a0_raw = 1'b0;
    cif.a4_raw = 1'b0;
    cif.i3_raw = 1'b0;
    test_reset();
    test_glitch();
    test_threshold();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
